// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM states and saturation limits for the FIR accumulator
package fir_pkg;
    localparam int ACC_W = 32;
    localparam logic [ACC_W-1:0] SAT_POS = 32'h7FFFFFFF;
    localparam logic [ACC_W-1:0] SAT_NEG = 32'h80000000;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/ripple_carry_adder_32bit.sv
// ripple_carry_adder_32bit: 32-bit ripple-carry adder, no carry-in or carry-out, sum wraps modulo 2^32
module ripple_carry_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic [31:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        if (i < 31) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
endmodule

// File: rtl/fir_acc_ctrl.sv
// fir_acc_ctrl: FIR MAC accumulator sequencer over the shared adder; FIR_ACC_SAT_EN enables signed saturation
module fir_acc_ctrl
    import fir_pkg::*;
#(
    parameter int TAPS = 16,
    parameter int W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      prod_valid,
    input  logic [W-1:0]              prod_data,
    output logic                      prod_ready,
    output logic [$clog2(TAPS)-1:0]   tap_idx,
    output logic [W-1:0]              acc_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      sat_flag
);
    localparam int IDX_W = $clog2(TAPS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(TAPS - 1);

    if (W != ACC_W) begin : g_bad_w
        $error("fir_acc_ctrl: W must equal the adder width of 32");
    end

    state_t           state_q;
    logic [W-1:0]     acc_q, acc_out_q, sum, acc_d;
    logic [IDX_W-1:0] tap_idx_q;
    logic             prod_ready_q, out_valid_q, busy_q, sat_q, sat_hit, hs, last;

    ripple_carry_adder_32bit u_add (
        .a   (acc_q),
        .b   (prod_data),
        .sum (sum)
    );

    assign hs   = prod_valid & prod_ready_q;
    assign last = tap_idx_q == LAST;

    // next accumulator value: raw wrapped sum, or clamped on signed overflow when saturation is built in
    always_comb begin
`ifdef FIR_ACC_SAT_EN
        sat_hit = (acc_q[W-1] == prod_data[W-1]) && (sum[W-1] != acc_q[W-1]);
        acc_d   = sat_hit ? (acc_q[W-1] ? SAT_NEG : SAT_POS) : sum;
`else
        sat_hit = 1'b0;
        acc_d   = sum;
`endif
    end

    // controller FSM with registered handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            acc_out_q    <= '0;
            tap_idx_q    <= '0;
            prod_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    acc_q        <= '0;
                    tap_idx_q    <= '0;
                    sat_q        <= 1'b0;
                    prod_ready_q <= 1'b1;
                    busy_q       <= 1'b1;
                    state_q      <= ACCUM;
                end
                ACCUM: if (hs) begin
                    acc_q     <= acc_d;
                    tap_idx_q <= last ? '0 : tap_idx_q + 1'b1;
                    if (sat_hit) sat_q <= 1'b1;
                    if (last) begin
                        acc_out_q    <= acc_d;
                        prod_ready_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prod_ready = prod_ready_q;
    assign tap_idx    = tap_idx_q;
    assign acc_out    = acc_out_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign sat_flag   = sat_q;
endmodule
